// File: rtl/fifo_rd_stream.sv
// Read-side stream controller for the synchronous FIFO: issues reads, absorbs the
// 1-cycle read latency in a 2-entry buffer. Optional counter: FIFO_RD_WORD_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
`ifdef FIFO_RD_WORD_CNT_EN
    output logic [CNT_WIDTH-1:0]  rd_word_cnt,
`endif
    output logic [1:0]            dbg_state
);

    // Handshake: a word transfers on a rising edge where m_valid & m_ready; while
    // m_valid is high and m_ready low, m_data holds and m_valid stays high.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head, tail;
    logic [1:0]            occ;
    logic                  rd_pend;
    logic                  pop;
    logic [2:0]            credit_used;

    assign m_valid   = (occ != 2'd0);
    assign pop       = m_valid & m_ready;
    assign m_data    = m_valid ? buf_mem[head] : '0;
    assign busy      = rd_pend | (occ != 2'd0);
    assign dbg_state = state;

    // A word leaving this cycle frees a slot, so m_ready feeds fifo_r_en directly.
    assign credit_used = {1'b0, occ} + {2'b00, rd_pend};
    assign fifo_r_en   = (state == RUN) & enable & ~fifo_empty &
                         (credit_used < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = FLUSH;
            FLUSH: begin
                if (occ == 2'd0 && !rd_pend) state_nxt = IDLE;
                else if (enable)             state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            occ        <= 2'd0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= fifo_r_en;
            if (rd_pend) begin
                buf_mem[tail] <= fifo_data;
                tail          <= ~tail;
            end
            if (pop) head <= ~head;
            occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

`ifdef FIFO_RD_WORD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rd_word_cnt <= '0;
        else if (pop) rd_word_cnt <= rd_word_cnt + 1'b1;
    end
`endif

endmodule
